// File: rtl/pwm_multi_avalon_if.sv
// ============================================================================
// pwm_multi_avalon_if: Avalon-MM slave bus bundle for the multi-channel PWM.
// Rev 1.0
// ============================================================================
`default_nettype none

interface pwm_multi_avalon_if;
  logic [3:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

`default_nettype wire

// File: rtl/pwm_multi_avalon.sv
// ============================================================================
// pwm_multi_avalon: NUM_CH PWM outputs on one shared edge/center counter with
// double-buffered period/duty. Macro PWM_IRQ_EN adds the irq port and IRQ_MASK.
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_multi_avalon #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pwm_multi_avalon_if.slave     bus,
  output logic [NUM_CH-1:0]     pwm_o
`ifdef PWM_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam logic [3:0] c_ADDR_CTRL   = 4'd0;
  localparam logic [3:0] c_ADDR_PERIOD = 4'd1;
  localparam logic [3:0] c_ADDR_PRE    = 4'd2;
  localparam logic [3:0] c_ADDR_STATUS = 4'd3;

  logic             r_en, r_center, r_center_sh, r_down, r_pend;
  logic [CNT_W-1:0] r_period, r_period_sh, r_cnt;
  logic [PRE_W-1:0] r_pre, r_pre_cnt;
  logic [CNT_W-1:0] r_duty    [NUM_CH];
  logic [CNT_W-1:0] r_duty_sh [NUM_CH];
`ifdef PWM_IRQ_EN
  logic             r_mask;
`endif

  logic             w_wr_ctrl, w_wr_status, w_en_next, w_tick, w_top, w_bnd;
  logic             w_down_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wr_ctrl   = bus.write && (bus.address == c_ADDR_CTRL);
  assign w_wr_status = bus.write && (bus.address == c_ADDR_STATUS);
  assign w_en_next   = w_wr_ctrl ? bus.writedata[0] : r_en;
  assign w_tick      = (r_pre_cnt == r_pre);
  assign w_top       = (r_cnt >= r_period_sh);
  assign w_unused    = ^bus.writedata;

  // Center boundary is the down-count tick at 1; P=1 never sets r_down, P=0 bounds every tick.
  always_comb begin
    w_bnd = 1'b0;
    if (r_en && w_tick) begin
      if (r_center_sh)
        w_bnd = (r_period_sh == '0) ||
                ((r_cnt == CNT_W'(1)) && (r_down || (r_period_sh == CNT_W'(1))));
      else
        w_bnd = w_top;
    end
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_down_nxt = r_down;
    if (w_bnd) begin
      w_cnt_nxt  = '0;
      w_down_nxt = 1'b0;
    end else if (w_tick) begin
      if (!r_center_sh || !w_top) begin
        w_cnt_nxt = r_down ? r_cnt - CNT_W'(1) : r_cnt + CNT_W'(1);
      end else begin
        w_cnt_nxt  = r_period_sh - CNT_W'(1);
        w_down_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      c_ADDR_CTRL: begin
        w_rdata[1:0] = {r_center, r_en};
`ifdef PWM_IRQ_EN
        w_rdata[2]   = r_mask;
`endif
      end
      c_ADDR_PERIOD: w_rdata[CNT_W-1:0] = r_period;
      c_ADDR_PRE:    w_rdata[PRE_W-1:0] = r_pre;
      c_ADDR_STATUS: w_rdata[0]         = r_pend;
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (bus.address[3] && (bus.address[2:0] == 3'(i)))
            w_rdata[CNT_W-1:0] = r_duty[i];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en        <= 1'b0;
      r_center    <= 1'b0;
      r_center_sh <= 1'b0;
      r_down      <= 1'b0;
      r_pend      <= 1'b0;
      r_period    <= '0;
      r_period_sh <= '0;
      r_cnt       <= '0;
      r_pre       <= '0;
      r_pre_cnt   <= '0;
      pwm_o       <= '0;
      bus.readdata <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty[i]    <= '0;
        r_duty_sh[i] <= '0;
      end
`ifdef PWM_IRQ_EN
      r_mask      <= 1'b0;
`endif
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= bus.writedata[0];
        r_center <= bus.writedata[1];
`ifdef PWM_IRQ_EN
        r_mask   <= bus.writedata[2];
`endif
      end
      if (bus.write && (bus.address == c_ADDR_PERIOD)) r_period <= bus.writedata[CNT_W-1:0];
      if (bus.write && (bus.address == c_ADDR_PRE))    r_pre    <= bus.writedata[PRE_W-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (bus.write && bus.address[3] && (bus.address[2:0] == 3'(i)))
          r_duty[i] <= bus.writedata[CNT_W-1:0];

      if (w_bnd)                                r_pend <= 1'b1;
      else if (w_wr_status && bus.writedata[0]) r_pend <= 1'b0;

      if (!r_en) begin
        r_cnt     <= '0;
        r_pre_cnt <= '0;
        r_down    <= 1'b0;
      end else begin
        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
        r_cnt     <= w_cnt_nxt;
        r_down    <= w_down_nxt;
      end

      // Shadows see the pre-write bus value when a write lands on the boundary cycle.
      if (!r_en || w_bnd) begin
        r_period_sh <= r_period;
        r_center_sh <= r_center;
        for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= r_duty[i];
      end

      for (int i = 0; i < NUM_CH; i++)
        pwm_o[i] <= r_en && w_en_next && (r_cnt < r_duty_sh[i]);

      bus.readdata <= bus.read ? w_rdata : '0;
    end
  end

`ifdef PWM_IRQ_EN
  assign irq = r_pend & r_mask;
`endif

endmodule

`default_nettype wire
